// File: rtl/axi_lite_up_slave.sv
// AXI4-Lite slave to single-cycle up request/acknowledge bridge.
// Independent read/write FSMs, one outstanding access each, with an ack timeout that answers SLVERR.
module axi_lite_up_slave #(
   parameter int ADDRESS_WIDTH  = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_aresetn,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   input  logic [15:0]              s_axi_awaddr,
   input  logic [2:0]               s_axi_awprot,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   input  logic [31:0]              s_axi_wdata,
   input  logic [3:0]               s_axi_wstrb,
   output logic                     s_axi_bvalid,
   output logic [1:0]               s_axi_bresp,
   input  logic                     s_axi_bready,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   input  logic [15:0]              s_axi_araddr,
   input  logic [2:0]               s_axi_arprot,
   output logic                     s_axi_rvalid,
   output logic [1:0]               s_axi_rresp,
   output logic [31:0]              s_axi_rdata,
   input  logic                     s_axi_rready,
   output logic                     up_wreq,
   output logic [ADDRESS_WIDTH-1:0] up_waddr,
   output logic [31:0]              up_wdata,
   input  logic                     up_wack,
   output logic                     up_rreq,
   output logic [ADDRESS_WIDTH-1:0] up_raddr,
   input  logic [31:0]              up_rdata,
   input  logic                     up_rack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   // Counter value at which the last permitted ack cycle has passed.
   localparam logic [7:0] TO_LAST     = 8'(TIMEOUT_CYCLES - 1);

   state_e                   wr_state_q, wr_state_d;
   logic [7:0]               wr_cnt_q, wr_cnt_d;
   logic [1:0]               bresp_q, bresp_d;
   logic [ADDRESS_WIDTH-1:0] up_waddr_q, up_waddr_d;
   logic [31:0]              up_wdata_q, up_wdata_d;

   state_e                   rd_state_q, rd_state_d;
   logic [7:0]               rd_cnt_q, rd_cnt_d;
   logic [1:0]               rresp_q, rresp_d;
   logic [31:0]              rdata_q, rdata_d;
   logic [ADDRESS_WIDTH-1:0] up_raddr_q, up_raddr_d;

   logic                     unused_ok;
   assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb, s_axi_awaddr, s_axi_araddr};

   // ---------------- write channel ----------------
   always_comb begin
      wr_state_d    = wr_state_q;
      wr_cnt_d      = wr_cnt_q;
      bresp_d       = bresp_q;
      up_waddr_d    = up_waddr_q;
      up_wdata_d    = up_wdata_q;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      up_wreq       = 1'b0;
      s_axi_bvalid  = 1'b0;
      case (wr_state_q)
         S_IDLE: begin
            if (s_axi_awvalid && s_axi_wvalid) begin
               wr_state_d = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            s_axi_awready = 1'b1;
            s_axi_wready  = 1'b1;
            up_waddr_d    = s_axi_awaddr[ADDRESS_WIDTH+1:2];
            up_wdata_d    = s_axi_wdata;
            wr_state_d    = S_REQ;
         end
         S_REQ: begin
            up_wreq  = 1'b1;
            wr_cnt_d = 8'd0;
            if (up_wack) begin
               bresp_d    = RESP_OKAY;
               wr_state_d = S_RESP;
            end else begin
               wr_state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            wr_cnt_d = wr_cnt_q + 8'd1;
            if (up_wack) begin
               bresp_d    = RESP_OKAY;
               wr_state_d = S_RESP;
            end else if (wr_cnt_d == TO_LAST) begin
               bresp_d    = RESP_SLVERR;
               wr_state_d = S_RESP;
            end
         end
         S_RESP: begin
            s_axi_bvalid = 1'b1;
            if (s_axi_bready) begin
               wr_state_d = S_IDLE;
            end
         end
         default: wr_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         wr_state_q <= S_IDLE;
         wr_cnt_q   <= 8'd0;
         bresp_q    <= 2'b00;
         up_waddr_q <= '0;
         up_wdata_q <= 32'd0;
      end else begin
         wr_state_q <= wr_state_d;
         wr_cnt_q   <= wr_cnt_d;
         bresp_q    <= bresp_d;
         up_waddr_q <= up_waddr_d;
         up_wdata_q <= up_wdata_d;
      end
   end

   // ---------------- read channel ----------------
   always_comb begin
      rd_state_d    = rd_state_q;
      rd_cnt_d      = rd_cnt_q;
      rresp_d       = rresp_q;
      rdata_d       = rdata_q;
      up_raddr_d    = up_raddr_q;
      s_axi_arready = 1'b0;
      up_rreq       = 1'b0;
      s_axi_rvalid  = 1'b0;
      case (rd_state_q)
         S_IDLE: begin
            if (s_axi_arvalid) begin
               rd_state_d = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            s_axi_arready = 1'b1;
            up_raddr_d    = s_axi_araddr[ADDRESS_WIDTH+1:2];
            rd_state_d    = S_REQ;
         end
         S_REQ: begin
            up_rreq  = 1'b1;
            rd_cnt_d = 8'd0;
            if (up_rack) begin
               rresp_d    = RESP_OKAY;
               rdata_d    = up_rdata;
               rd_state_d = S_RESP;
            end else begin
               rd_state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            rd_cnt_d = rd_cnt_q + 8'd1;
            if (up_rack) begin
               rresp_d    = RESP_OKAY;
               rdata_d    = up_rdata;
               rd_state_d = S_RESP;
            end else if (rd_cnt_d == TO_LAST) begin
               // Timed-out reads return zero so stale data never leaks out.
               rresp_d    = RESP_SLVERR;
               rdata_d    = 32'd0;
               rd_state_d = S_RESP;
            end
         end
         S_RESP: begin
            s_axi_rvalid = 1'b1;
            if (s_axi_rready) begin
               rd_state_d = S_IDLE;
            end
         end
         default: rd_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         rd_state_q <= S_IDLE;
         rd_cnt_q   <= 8'd0;
         rresp_q    <= 2'b00;
         rdata_q    <= 32'd0;
         up_raddr_q <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_cnt_q   <= rd_cnt_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         up_raddr_q <= up_raddr_d;
      end
   end

   assign s_axi_bresp = bresp_q;
   assign up_waddr    = up_waddr_q;
   assign up_wdata    = up_wdata_q;
   assign s_axi_rresp = rresp_q;
   assign s_axi_rdata = rdata_q;
   assign up_raddr    = up_raddr_q;

endmodule

// File: tb/tb_axi_lite_up_slave.sv
// Bench for axi_lite_up_slave: vector table of single accesses with a response scoreboard,
// plus hand-written sequences for handshake gating, concurrency and mid-transaction reset.
module tb_axi_lite_up_slave;
   localparam int AW = 8;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic [15:0]   awaddr = 0, araddr = 0;
   logic [31:0]   wdata = 0;
   logic          awready, wready, bvalid, arready, rvalid;
   logic [1:0]    bresp, rresp;
   logic [31:0]   rdata;
   logic          up_wreq, up_rreq;
   logic [AW-1:0] up_waddr, up_raddr;
   logic [31:0]   up_wdata;
   logic          up_wack = 0, up_rack = 0;
   logic [31:0]   up_rdata = 0;

   axi_lite_up_slave #(.ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(4'hF),
      .s_axi_bvalid(bvalid), .s_axi_bresp(bresp), .s_axi_bready(bready),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arprot(3'b000),
      .s_axi_rvalid(rvalid), .s_axi_rresp(rresp), .s_axi_rdata(rdata), .s_axi_rready(rready),
      .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
      .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_read;
      logic [15:0] addr;
      logic [31:0] data;      // wdata for writes, core read data for reads
      int          ack_delay; // cycles after the request; -1 = never
      int          late_ack;  // cycle (relative to N) of a stray ack; 0 = none
      int          hold;      // cycles the response is held off
      logic [7:0]  exp_uaddr;
      int          exp_lat;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      int          lat;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string name);
      logic [90:0] outs;
      outs = {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata,
              up_wreq, up_waddr, up_wdata, up_rreq, up_raddr};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL %s: outputs %h expected all zero", name, outs);
      end
   endtask

   function automatic logic resp_valid(input bit rd);
      return rd ? rvalid : bvalid;
   endfunction

   function automatic logic [1:0] cur_resp(input bit rd);
      return rd ? rresp : bresp;
   endfunction

   task automatic drive_ack(input bit rd, input bit ack, input logic [31:0] d);
      if (rd) begin
         up_rack  = ack;
         up_rdata = ack ? d : 32'h5A5A_0F0F;
      end else begin
         up_wack = ack;
      end
   endtask

   task automatic set_ready(input bit rd, input logic v);
      if (rd) rready = v;
      else    bready = v;
   endtask

   task automatic run_txn(input vec_t v);
      exp_t e;
      exp_t got;
      int   c;
      e.lat = v.exp_lat; e.resp = v.exp_resp; e.rdata = v.exp_rdata;
      sb.push_back(e);
      // cycle N
      if (v.is_read) begin
         arvalid = 1; araddr = v.addr;
      end else begin
         awvalid = 1; wvalid = 1; awaddr = v.addr; wdata = v.data;
      end
      tick(); // N+1
      if (v.is_read) chk("arready", 32'(arready), 32'd1);
      else           chk("aw_w_ready", 32'({awready, wready}), 32'd3);
      tick(); // N+2
      awvalid = 0; wvalid = 0; arvalid = 0;
      awaddr = 16'hFFFF; araddr = 16'hFFFF; wdata = 32'h0;
      if (v.is_read) begin
         chk("up_rreq", 32'(up_rreq), 32'd1);
         chk("up_raddr", 32'(up_raddr), 32'(v.exp_uaddr));
         chk("arready_once", 32'(arready), 32'd0);
      end else begin
         chk("up_wreq", 32'(up_wreq), 32'd1);
         chk("up_waddr", 32'(up_waddr), 32'(v.exp_uaddr));
         chk("up_wdata", up_wdata, v.data);
         chk("aw_w_ready_once", 32'({awready, wready}), 32'd0);
      end
      c = 2;
      while (!resp_valid(v.is_read) && c < 2 + TO + 4) begin
         drive_ack(v.is_read, (v.ack_delay >= 0 && c == 2 + v.ack_delay) || c == v.late_ack, v.data);
         tick();
         c++;
         drive_ack(v.is_read, 1'b0, 32'h0);
         if (c == 3) chk("req_one_cycle", 32'(v.is_read ? up_rreq : up_wreq), 32'd0);
      end
      got = sb.pop_front();
      if (!resp_valid(v.is_read)) begin
         checks++;
         errors++;
         $display("FAIL resp_wait: no response valid after %0d cycles, expected at %0d", c, got.lat);
         return;
      end
      chk("latency", 32'(c), 32'(got.lat));
      chk("resp", 32'(cur_resp(v.is_read)), 32'(got.resp));
      if (v.is_read) chk("rdata", rdata, got.rdata);
      for (int h = 0; h < v.hold; h++) begin
         drive_ack(v.is_read, c == v.late_ack, v.data);
         tick();
         c++;
         drive_ack(v.is_read, 1'b0, 32'h0);
         chk("hold_valid", 32'(resp_valid(v.is_read)), 32'd1);
         chk("hold_resp", 32'(cur_resp(v.is_read)), 32'(got.resp));
         if (v.is_read) chk("hold_rdata", rdata, got.rdata);
      end
      set_ready(v.is_read, 1'b1);
      tick();
      set_ready(v.is_read, 1'b0);
      chk("valid_drop", 32'(resp_valid(v.is_read)), 32'd0);
      if (v.is_read) chk("raddr_held", 32'(up_raddr), 32'(v.exp_uaddr));
      else           chk("waddr_held", 32'(up_waddr), 32'(v.exp_uaddr));
   endtask

   vec_t vecs[8];
   vec_t extra;

   initial begin
      //                 rd    addr      data          ack late hold uaddr lat resp   rdata
      vecs[0] = '{1'b0, 16'h0008, 32'hA5A55A5A,  1, 0, 0, 8'h02, 4, 2'b00, 32'h0};
      vecs[1] = '{1'b1, 16'h0084, 32'h12345678,  1, 0, 3, 8'h21, 4, 2'b00, 32'h12345678};
      vecs[2] = '{1'b1, 16'h0010, 32'hDEADBEEF, -1, 8, 4, 8'h04, 6, 2'b10, 32'h0};
      vecs[3] = '{1'b0, 16'hFFFC, 32'h00000001,  0, 0, 1, 8'hFF, 3, 2'b00, 32'h0};
      vecs[4] = '{1'b0, 16'h0403, 32'hC0FFEE00,  3, 0, 0, 8'h00, 6, 2'b00, 32'h0};
      vecs[5] = '{1'b0, 16'h0020, 32'h77777777, -1, 0, 2, 8'h08, 6, 2'b10, 32'h0};
      vecs[6] = '{1'b1, 16'h00FF, 32'h0BADF00D,  0, 0, 0, 8'h3F, 3, 2'b00, 32'h0BADF00D};
      vecs[7] = '{1'b1, 16'h0200, 32'hCAFEBABE,  3, 0, 1, 8'h80, 6, 2'b00, 32'hCAFEBABE};

      rst_n = 0;
      tick();
      tick();
      chk_zero("reset_state");
      rst_n = 1;
      tick();

      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i]);
         tick();
      end

      // lone wvalid must not be accepted
      wvalid = 1; wdata = 32'h1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("lone_w_ready", 32'({awready, wready}), 32'd0);
      end
      wvalid = 0;
      tick();

      // awvalid 5 cycles ahead of wvalid
      awvalid = 1; awaddr = 16'h0030;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("lone_aw_ready", 32'({awready, wready}), 32'd0);
      end
      extra = '{1'b0, 16'h0030, 32'h13579BDF, 1, 0, 0, 8'h0C, 4, 2'b00, 32'h0};
      run_txn(extra);
      tick();

      // concurrent write and read, both acked one cycle after the request
      awvalid = 1; wvalid = 1; awaddr = 16'h0014; wdata = 32'hFEEDFACE;
      arvalid = 1; araddr = 16'h0018;
      tick(); // N+1
      chk("conc_ready", 32'({awready, wready, arready}), 32'd7);
      tick(); // N+2
      awvalid = 0; wvalid = 0; arvalid = 0;
      chk("conc_reqs", 32'({up_wreq, up_rreq}), 32'd3);
      chk("conc_addrs", 32'({up_waddr, up_raddr}), 32'h0506);
      tick(); // N+3
      chk("conc_no_early", 32'({bvalid, rvalid}), 32'd0);
      up_wack = 1; up_rack = 1; up_rdata = 32'h600DCAFE;
      tick(); // N+4
      up_wack = 0; up_rack = 0; up_rdata = 32'h0;
      chk("conc_valids", 32'({bvalid, rvalid}), 32'd3);
      chk("conc_resps", 32'({bresp, rresp}), 32'd0);
      chk("conc_rdata", rdata, 32'h600DCAFE);
      bready = 1; rready = 1;
      tick();
      bready = 0; rready = 0;
      chk("conc_done", 32'({bvalid, rvalid}), 32'd0);
      tick();

      // reset while the write FSM waits for an ack
      awvalid = 1; wvalid = 1; awaddr = 16'h0044; wdata = 32'h11112222;
      tick();
      tick();
      awvalid = 0; wvalid = 0;
      tick();
      tick(); // write FSM in WAIT
      chk("pre_reset_waddr", 32'(up_waddr), 32'h11);
      rst_n = 0;
      #1;
      chk_zero("async_reset");
      tick();
      tick();
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("aborted_no_resp", 32'(bvalid), 32'd0);
      end
      extra = '{1'b0, 16'h0048, 32'h33334444, 1, 0, 1, 8'h12, 4, 2'b00, 32'h0};
      run_txn(extra);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/axi_lite_up_slave.md
# axi_lite_up_slave

AXI4-Lite slave front end that converts AXI4-Lite register accesses into the single-cycle request/acknowledge microprocessor (up) bus used by the register files of the team's peripheral cores, such as the system-ID block. It sits directly upstream of a core's register decode logic. Its read and write channels are independent, and each channel allows one outstanding transaction. A per-channel timeout converts a missing up acknowledge into an AXI SLVERR response, so a misdecoded address can never hang the interconnect.

## Interface
Parameters:
- ADDRESS_WIDTH, 8: up word-address width; up address = AXI byte address bits [ADDRESS_WIDTH+1:2].
- TIMEOUT_CYCLES, 64: maximum number of cycles to wait for up_wack/up_rack, counted from the request cycle; legal range 2..255.

Ports:
- s_axi_aclk  in  1  single clock for all logic.
- s_axi_aresetn  in  1  reset; asynchronous assert, active-low.
- s_axi_awvalid / s_axi_awready  in/out  1  write-address handshake.
- s_axi_awaddr  in  16  write byte address.
- s_axi_awprot  in  3  ignored.
- s_axi_wvalid / s_axi_wready  in/out  1  write-data handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  ignored; every write is a full word.
- s_axi_bvalid  out  1  write-response valid.
- s_axi_bresp  out  2  write response: 00 = OKAY, 10 = SLVERR.
- s_axi_bready  in  1  write-response ready.
- s_axi_arvalid / s_axi_arready  in/out  1  read-address handshake.
- s_axi_araddr  in  16  read byte address.
- s_axi_arprot  in  3  ignored.
- s_axi_rvalid  out  1  read-data valid.
- s_axi_rresp  out  2  read response: 00 = OKAY, 10 = SLVERR.
- s_axi_rdata  out  32  read data.
- s_axi_rready  in  1  read-data ready.
- up_wreq  out  1  one-cycle write strobe.
- up_waddr  out  ADDRESS_WIDTH  write word address.
- up_wdata  out  32  write data.
- up_wack  in  1  write acknowledge.
- up_rreq  out  1  one-cycle read strobe.
- up_raddr  out  ADDRESS_WIDTH  read word address.
- up_rdata  in  32  read data; valid in the same cycle as up_rack.
- up_rack  in  1  read acknowledge.

## Operation
- Reset value of every output is 0, including all readies, valids, responses, addresses, data and strobes.
- Write FSM states:
  - IDLE: when awvalid && wvalid, go to ACCEPT. A lone awvalid or a lone wvalid is not accepted.
  - ACCEPT: awready = wready = 1 for exactly one cycle. Latch awaddr[ADDRESS_WIDTH+1:2] and wdata. Go to REQ.
  - REQ: up_wreq = 1 for one cycle. Load the timeout counter with 0. If up_wack is high in this cycle, go to RESP with OKAY; otherwise go to WAIT.
  - WAIT: increment the counter each cycle.
    - up_wack high: go to RESP with OKAY.
    - Counter reaches TIMEOUT_CYCLES-1 without up_wack: go to RESP with SLVERR.
  - RESP: bvalid = 1 and bresp is held stable until bready. Go to IDLE in the cycle after bvalid && bready.
- Read FSM has the same structure (IDLE, ACCEPT, REQ, WAIT, RESP) on arvalid/arready, up_rreq and up_rack.
  - When up_rack is high, capture up_rdata into rdata.
  - On timeout, rdata = 0 and rresp = 10.
  - rdata and rresp are held stable while rvalid && !rready.
- up_waddr/up_wdata and up_raddr hold their latched values after the request; they change only in ACCEPT.
- An up_wack or up_rack arriving while its FSM is not in REQ or WAIT is ignored. A late ack after a timeout is therefore dropped.
- Read and write channels run fully concurrently; simultaneous up_wreq and up_rreq is legal.
- Address bits [1:0] and bits above ADDRESS_WIDTH+1 are discarded.

## Timing
- Cycle N: valids sampled in IDLE. N+1: ready pulse, which is the AXI handshake. N+2: up_wreq/up_rreq.
- Ack in cycle N+2+k, with k ≥ 0 and k < TIMEOUT_CYCLES: bvalid/rvalid rises at N+3+k.
- Registered-ack core, where ack follows the request by one cycle: bvalid/rvalid at N+4.
- No ack: SLVERR response valid at N+2+TIMEOUT_CYCLES.
- Back-to-back transactions: the next ACCEPT is no earlier than the cycle after the response handshake.
- Reset asserted mid-transaction clears both FSMs, all outputs and the counters immediately. The aborted transaction gets no response. Operation resumes from IDLE on the first clock after deassertion.

## Test plan
- Write awaddr = 0x0008, wdata = 0xA5A55A5A, ack one cycle after up_wreq -> up_waddr = 0x02, up_wdata = 0xA5A55A5A, one-cycle up_wreq at N+2, bvalid at N+4 with bresp = 00.
- Read araddr = 0x0084, up_rack with up_rdata = 0x12345678 one cycle after up_rreq, rready held low 3 cycles -> up_raddr = 0x21, rvalid at N+4, rdata = 0x12345678 and rresp = 00 stable until rready.
- Read with up_rack never asserted, TIMEOUT_CYCLES = 4 -> rvalid at N+6, rresp = 10, rdata = 0; an up_rack pulse 2 cycles later has no effect.
- awvalid high 5 cycles before wvalid -> no awready until wvalid is high; awready and wready then pulse together exactly once.
- Write and read issued in the same cycle, both acked one cycle after request -> up_wreq and up_rreq asserted together at N+2; bvalid and rvalid both at N+4.
- Reset asserted while the write FSM is in WAIT -> all outputs 0 immediately; after release, a new write completes normally with OKAY.
